// File: rtl/fuzz_seq_pkg.sv
// Shared types, LCG constants and LCG step function for the fuzz stimulus generators.
package fuzz_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        FILL,
        APPLY,
        DONE
    } seq_state_e;

    localparam logic [31:0] LCG_A_DEFAULT = 32'h41C64E6D;
    localparam logic [31:0] LCG_C_DEFAULT = 32'h0000_3039;

    function automatic logic [31:0] lcg_next(
        input logic [31:0] s,
        input logic [31:0] a = LCG_A_DEFAULT,
        input logic [31:0] c = LCG_C_DEFAULT
    );
        return s * a + c;
    endfunction

endpackage

// File: rtl/fuzz_lcg32.sv
// Registered 32-bit LCG: load a seed, advance one step per asserted step cycle.
module fuzz_lcg32
    import fuzz_seq_pkg::*;
#(
    parameter logic [31:0] LCG_A = LCG_A_DEFAULT,
    parameter logic [31:0] LCG_C = LCG_C_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] state,
    output logic [31:0] nxt
);

    assign nxt = lcg_next(state, LCG_A, LCG_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// LCG-driven stimulus sequencer: holds DUT reset, fills IN_W-bit vectors one 32-bit
// word per clock, commits each with a dut_ce strobe and counts vectors until done.
module fuzz_stim_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int          IN_W      = 261,
    parameter int          RESET_CYC = 2,
    parameter logic [31:0] LCG_A     = LCG_A_DEFAULT,
    parameter logic [31:0] LCG_C     = LCG_C_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [31:0]     seed_i,
    input  logic [31:0]     cycles_i,
    output logic            busy,
    output logic            done,
    output logic            dut_rst_n,
    output logic            dut_ce,
    output logic [IN_W-1:0] dut_in,
    output logic [31:0]     vec_cnt,
    output logic [31:0]     lcg_state
);

    localparam int              NW      = (IN_W + 31) / 32;
    localparam int              KW      = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0]   K_LAST  = KW'(NW - 1);
    localparam logic [31:0]     RC_LAST = 32'(RESET_CYC - 1);

    seq_state_e      state, state_nxt;
    logic [KW-1:0]   k;
    logic [31:0]     rst_cnt;
    logic [31:0]     limit;
    logic [IN_W-1:0] shadow;
    logic [31:0]     lcg_nxt;
    logic            lcg_load;
    logic            lcg_step;
    logic            commit;
    logic            last_vec;

    fuzz_lcg32 #(
        .LCG_A (LCG_A),
        .LCG_C (LCG_C)
    ) u_lcg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lcg_load),
        .load_val (seed_i),
        .step     (lcg_step),
        .state    (lcg_state),
        .nxt      (lcg_nxt)
    );

    // 33-bit compare so cycles_i = 32'hFFFFFFFF yields 2^32 vectors instead of never ending.
    assign last_vec = ({1'b0, vec_cnt} + 33'd1) == ({1'b0, limit} + 33'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lcg_load  = 1'b0;
        lcg_step  = 1'b0;
        commit    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    lcg_load  = 1'b1;
                    state_nxt = RESET;
                end
            end
            RESET: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = DONE;
                end else if (rst_cnt == RC_LAST) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = DONE;
                end else begin
                    lcg_step = 1'b1;
                    if (k == K_LAST) begin
                        state_nxt = APPLY;
                    end
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = DONE;
                end else begin
                    commit    = 1'b1;
                    state_nxt = last_vec ? DONE : FILL;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            rst_cnt   <= '0;
            limit     <= '0;
            vec_cnt   <= '0;
            dut_in    <= '0;
            dut_ce    <= 1'b0;
            dut_rst_n <= 1'b0;
        end else begin
            dut_ce <= commit;
            if (lcg_load) begin
                k         <= '0;
                rst_cnt   <= '0;
                limit     <= cycles_i;
                vec_cnt   <= '0;
                dut_rst_n <= 1'b0;
            end
            if (state == RESET) begin
                rst_cnt <= rst_cnt + 32'd1;
                if (state_nxt == FILL) begin
                    dut_rst_n <= 1'b1;
                end
            end
            if (lcg_step) begin
                k <= (k == K_LAST) ? '0 : k + 1'b1;
            end
            if (commit) begin
                dut_in    <= shadow;
                vec_cnt   <= vec_cnt + 32'd1;
                dut_rst_n <= 1'b1;
            end
        end
    end

    // One register per word; the top word keeps only the IN_W-32*(NW-1) LSBs of the LCG output.
    for (genvar g = 0; g < NW; g++) begin : g_word
        localparam int LO = 32 * g;
        localparam int WB = (g == NW - 1) ? (IN_W - LO) : 32;
        logic [WB-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (lcg_step && (k == KW'(g))) begin
                word_q <= lcg_nxt[WB-1:0];
            end
        end

        assign shadow[LO +: WB] = word_q;
    end

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Self-checking bench for fuzz_stim_sequencer: 261-, 32- and 33-bit builds side by side
// against an LCG chunking model.
module tb_fuzz_stim_sequencer;

    localparam logic [31:0] LA    = 32'h41C64E6D;
    localparam logic [31:0] LC    = 32'h00003039;
    localparam int          RC    = 2;
    localparam int          DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] seed_i = '0;
    logic [31:0] cycles_i = '0;

    logic         busy0, done0, drn0, ce0;
    logic [260:0] in0;
    logic [31:0]  cnt0, lcg0;
    logic         busy1, done1, drn1, ce1;
    logic [31:0]  in1;
    logic [31:0]  cnt1, lcg1;
    logic         busy2, done2, drn2, ce2;
    logic [32:0]  in2;
    logic [31:0]  cnt2, lcg2;

    fuzz_stim_sequencer #(.IN_W(261), .RESET_CYC(RC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_i(seed_i), .cycles_i(cycles_i),
        .busy(busy0), .done(done0), .dut_rst_n(drn0), .dut_ce(ce0), .dut_in(in0),
        .vec_cnt(cnt0), .lcg_state(lcg0));

    fuzz_stim_sequencer #(.IN_W(32), .RESET_CYC(RC)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_i(seed_i), .cycles_i(cycles_i),
        .busy(busy1), .done(done1), .dut_rst_n(drn1), .dut_ce(ce1), .dut_in(in1),
        .vec_cnt(cnt1), .lcg_state(lcg1));

    fuzz_stim_sequencer #(.IN_W(33), .RESET_CYC(RC)) dut33 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_i(seed_i), .cycles_i(cycles_i),
        .busy(busy2), .done(done2), .dut_rst_n(drn2), .dut_ce(ce2), .dut_in(in2),
        .vec_cnt(cnt2), .lcg_state(lcg2));

    always #5 clk = ~clk;

    logic         ce_a   [3];
    logic         dn_a   [3];
    logic         busy_a [3];
    logic [260:0] vin    [3];
    logic [31:0]  cnt_a  [3];

    assign ce_a[0] = ce0;   assign ce_a[1] = ce1;   assign ce_a[2] = ce2;
    assign dn_a[0] = done0; assign dn_a[1] = done1; assign dn_a[2] = done2;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1; assign busy_a[2] = busy2;
    assign vin[0] = in0;
    assign vin[1] = {229'd0, in1};
    assign vin[2] = {228'd0, in2};
    assign cnt_a[0] = cnt0; assign cnt_a[1] = cnt1; assign cnt_a[2] = cnt2;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Commit log per instance, sampled on the falling edge.
    int unsigned  ce_n   [3] = '{0, 0, 0};
    int unsigned  done_n [3] = '{0, 0, 0};
    int unsigned  ce_t   [3][DEPTH];
    logic [260:0] ce_v   [3][DEPTH];
    logic [31:0]  ce_c   [3][DEPTH];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ce_a[d]) begin
                ce_t[d][ce_n[d] % DEPTH] <= cyc;
                ce_v[d][ce_n[d] % DEPTH] <= vin[d];
                ce_c[d][ce_n[d] % DEPTH] <= cnt_a[d];
                ce_n[d] <= ce_n[d] + 1;
            end
            if (dn_a[d]) done_n[d] <= done_n[d] + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [260:0] act, input logic [260:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int unsigned width_of(input int d);
        return (d == 0) ? 261 : (d == 1) ? 32 : 33;
    endfunction

    // Vector idx of a run: the (idx+1)-th group of ceil(w/32) LCG outputs, word k at bit 32k, masked to w bits.
    function automatic logic [260:0] model_vec(input logic [31:0] seed, input int unsigned idx, input int unsigned w);
        logic [31:0]  s;
        logic [287:0] v;
        logic [287:0] m;
        int unsigned  nw;
        s  = seed;
        v  = '0;
        nw = (w + 31) / 32;
        for (int unsigned i = 0; i <= idx; i++) begin
            for (int unsigned k = 0; k < nw; k++) begin
                s = s * LA + LC;
                v[32*k +: 32] = s;
            end
        end
        m = (288'(1) << w) - 288'(1);
        v = v & m;
        return v[260:0];
    endfunction

    task automatic run_check(input logic [31:0] seed, input logic [31:0] ncyc, input int unsigned exp_n,
                             input int unsigned lat0, input int unsigned per0, input bit poke,
                             output logic [260:0] first_vec);
        int unsigned base [3];
        int unsigned dbase [3];
        int unsigned s, nw, lat, per, got, idx;
        bit fin;
        for (int d = 0; d < 3; d++) begin
            base[d]  = ce_n[d];
            dbase[d] = done_n[d];
        end
        seed_i = seed; cycles_i = ncyc; start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        chk("busy_on_start", busy0, 1);
        chk("dut_rst_n_reset_clk1", drn0, 0);
        step();
        chk("dut_rst_n_reset_clk2", drn0, 0);
        step();
        chk("dut_rst_n_first_fill", drn0, 1);
        if (poke) begin
            repeat (3) step();
            seed_i = ~seed; cycles_i = 0; start = 1'b1;
            step();
            start = 1'b0;
            chk("busy_after_restart_poke", busy0, 1);
        end
        fin = 1'b0;
        for (int unsigned i = 0; i < exp_n * per0 + 64 && !fin; i++) begin
            step();
            fin = (done_n[0] != dbase[0]) && (done_n[1] != dbase[1]) && (done_n[2] != dbase[2]);
        end
        chk("run_done_within_budget", fin, 1);
        for (int d = 0; d < 3; d++) begin
            nw  = (width_of(d) + 31) / 32;
            lat = (d == 0) ? lat0 : 1 + RC + nw;
            per = (d == 0) ? per0 : nw + 1;
            got = ce_n[d] - base[d];
            chk("vector_count", got, exp_n);
            chk("done_pulses", done_n[d] - dbase[d], 1);
            for (int unsigned i = 0; i < got && i < exp_n; i++) begin
                idx = (base[d] + i) % DEPTH;
                chk("dut_ce_timing", ce_t[d][idx] - s, lat + i * per);
                chk("dut_in_value", ce_v[d][idx], model_vec(seed, i, width_of(d)));
                chk("vec_cnt_at_commit", ce_c[d][idx], i + 1);
            end
            chk("busy_after_done", busy_a[d], 0);
        end
        first_vec = ce_v[0][base[0] % DEPTH];
    endtask

    typedef struct {
        logic [31:0] seed;
        logic [31:0] ncyc;
        int unsigned exp_n;
        int unsigned lat;
        int unsigned per;
        bit          poke;
    } run_t;

    run_t tbl [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [260:0] fv;
        logic [31:0]  rseed;
        logic [31:0]  rcyc;
        int unsigned  b, db, s;

        tbl[0] = '{seed: 32'd0,          ncyc: 32'd0,   exp_n: 1,   lat: 12, per: 10, poke: 1'b0};
        tbl[1] = '{seed: 32'd1025148381, ncyc: 32'd100, exp_n: 101, lat: 12, per: 10, poke: 1'b0};
        tbl[2] = '{seed: 32'hDEADBEEF,   ncyc: 32'd4,   exp_n: 5,   lat: 12, per: 10, poke: 1'b1};
        for (int i = 3; i < 5; i++) begin
            rseed = $urandom;
            rcyc  = $urandom_range(1, 6);
            tbl[i] = '{seed: rseed, ncyc: rcyc, exp_n: rcyc + 1, lat: 12, per: 10, poke: 1'b0};
        end

        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_dut_rst_n", drn0, 0);
        chk("reset_dut_ce", ce0, 0);
        chk("reset_dut_in", in0, 0);
        chk("reset_vec_cnt", cnt0, 0);
        chk("reset_lcg_state", lcg0, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_check(tbl[i].seed, tbl[i].ncyc, tbl[i].exp_n, tbl[i].lat, tbl[i].per, tbl[i].poke, fv);
            if (i == 0) begin
                chk("seed0_word0", fv[31:0], 32'h00003039);
                chk("seed0_word1", fv[63:32], 32'hD3DC167E);
            end
            repeat (2) step();
        end

        // Abort in the 4th FILL cycle of vector 3.
        b = ce_n[0]; db = done_n[0];
        seed_i = 32'h12345678; cycles_i = 32'd10; start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        for (int unsigned i = 0; i < 100 && (ce_n[0] - b) < 2; i++) step();
        chk("abort_reached_vector2", ce_n[0] - b, 2);
        repeat (3) step();
        chk("abort_at_fill4_time", cyc - s, 25);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_next_clk", done0, 1);
        chk("abort_busy_low", busy0, 0);
        chk("abort_vec_cnt", cnt0, 2);
        chk("abort_dut_in_is_vec2", in0, model_vec(32'h12345678, 1, 261));
        chk("abort_no_ce", ce0, 0);
        repeat (15) step();
        chk("abort_no_further_ce", ce_n[0] - b, 2);
        chk("abort_single_done", done_n[0] - db, 1);

        // start together with abort in IDLE must not launch a run.
        b = ce_n[0];
        seed_i = 32'h1; cycles_i = 32'd3; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle_busy", busy0, 0);
        repeat (20) step();
        chk("start_abort_idle_busy_later", busy0, 0);
        chk("start_abort_idle_vec_cnt", cnt0, 2);
        chk("start_abort_idle_dut_rst_n", drn0, 1);
        chk("start_abort_idle_no_ce", ce_n[0] - b, 0);

        // rst_n pulsed while the 261-bit instance sits in APPLY.
        b = ce_n[0];
        seed_i = 32'd0; cycles_i = 32'd0; start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        repeat (11) step();
        chk("apply_reset_time", cyc - s, 11);
        chk("apply_reset_not_yet_committed", ce_n[0] - b, 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", busy0, 0);
        chk("async_reset_done", done0, 0);
        chk("async_reset_dut_rst_n", drn0, 0);
        chk("async_reset_dut_ce", ce0, 0);
        chk("async_reset_dut_in", in0, 0);
        chk("async_reset_vec_cnt", cnt0, 0);
        chk("async_reset_lcg_state", lcg0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("after_reset_no_commit", ce_n[0] - b, 0);
        run_check(32'd0, 32'd0, 1, 12, 10, 1'b0, fv);
        chk("rerun_seed0_word0", fv[31:0], 32'h00003039);
        chk("rerun_seed0_word1", fv[63:32], 32'hD3DC167E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
